// File: rtl/leg_core_p_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leg_core_p_if : instruction-fetch and byte-I/O handshake bundle of leg_core_p
// Rev 1.0
// ----------------------------------------------------------------------------
interface leg_core_p_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic                pm_req;
  logic [PC_W-1:0]     pm_addr;
  logic                pm_valid;
  logic [4*DATA_W-1:0] pm_data;

  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;

  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;

  // master is the core side; slave is program memory plus the I/O ports
  modport master (
    output pm_req, pm_addr,
    input  pm_valid, pm_data,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  pm_req, pm_addr,
    output pm_valid, pm_data,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/leg_core_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leg_core_p : parametrised multi-cycle LEG core with handshaked fetch and I/O
// Rev 1.0
// ----------------------------------------------------------------------------
module leg_core_p #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 6,
  parameter int PC_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  leg_core_p_if.master core_if,
  output logic         halted_o
);

  localparam logic [3:0] SEL_PC = 4'd14;
  localparam logic [3:0] SEL_IO = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_IN_WAIT  = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [4*DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]   tok_q, tok_d;
  logic                tok_vld_q, tok_vld_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic [DATA_W-1:0]   opc_f, arg1_f, arg2_f, dest_f;
  logic                arg1_imm, arg2_imm, is_cond, is_halt;
  logic [2:0]          op;
  logic [3:0]          arg1_sel, arg2_sel, dest_sel;
  logic [DATA_W-1:0]   arg1_rd, arg2_rd, a1, a2;
  logic [DATA_W-1:0]   alu_res;
  logic                taken;
  logic                need_in;
  logic                wr_en;
  logic [PC_W-1:0]     pc_inc;

  // Instruction word layout: {dest, arg2, arg1, opcode}, opcode in the LSBs.
  assign opc_f    = instr_q[DATA_W-1:0];
  assign arg1_f   = instr_q[2*DATA_W-1:DATA_W];
  assign arg2_f   = instr_q[3*DATA_W-1:2*DATA_W];
  assign dest_f   = instr_q[4*DATA_W-1:3*DATA_W];

  assign arg1_imm = opc_f[7];
  assign arg2_imm = opc_f[6];
  assign is_cond  = opc_f[5];
  assign is_halt  = opc_f[4];
  assign op       = opc_f[2:0];

  assign arg1_sel = arg1_f[3:0];
  assign arg2_sel = arg2_f[3:0];
  assign dest_sel = dest_f[3:0];

  assign pc_inc   = pc_q + PC_W'(4);

  // Opcode bit 3 is reserved and dest upper bits only matter for jumps.
  logic unused_bits;
  assign unused_bits = ^{opc_f, dest_f};

  // Operand select: registers, the current instruction's PC, or the input token.
  always_comb begin
    arg1_rd = '0;
    arg2_rd = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (arg1_sel == 4'(i)) arg1_rd = regs_q[i];
      if (arg2_sel == 4'(i)) arg2_rd = regs_q[i];
    end
    if (arg1_sel == SEL_PC) arg1_rd = DATA_W'(pc_q);
    if (arg2_sel == SEL_PC) arg2_rd = DATA_W'(pc_q);
    if (arg1_sel == SEL_IO) arg1_rd = tok_q;
    if (arg2_sel == SEL_IO) arg2_rd = tok_q;
  end

  assign a1 = arg1_imm ? arg1_f : arg1_rd;
  assign a2 = arg2_imm ? arg2_f : arg2_rd;

  assign need_in = (!arg1_imm && (arg1_sel == SEL_IO)) ||
                   (!arg2_imm && (arg2_sel == SEL_IO));

  always_comb begin
    alu_res = '0;
    case (op)
      3'd0:    alu_res = a1 + a2;
      3'd1:    alu_res = a1 - a2;
      3'd2:    alu_res = a1 & a2;
      3'd3:    alu_res = a1 | a2;
      3'd4:    alu_res = ~a1;
      3'd5:    alu_res = a1 ^ a2;
      3'd6:    alu_res = a1 << a2[2:0];
      3'd7:    alu_res = a1 >> a2[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      3'd0:    taken = (a1 == a2);
      3'd1:    taken = (a1 != a2);
      3'd2:    taken = (a1 <  a2);
      3'd3:    taken = (a1 <= a2);
      3'd4:    taken = (a1 >  a2);
      3'd5:    taken = (a1 >= a2);
      3'd6:    taken = 1'b1;
      3'd7:    taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    tok_d     = tok_q;
    tok_vld_d = tok_vld_q;
    out_d     = out_q;
    wr_en     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (core_if.pm_valid) begin
          instr_d = core_if.pm_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (need_in && !tok_vld_q) begin
          state_d = S_IN_WAIT;
        end else begin
          // One token serves every operand selecting I/O, then it is spent.
          tok_vld_d = 1'b0;
          state_d   = S_FETCH;
          if (is_cond) begin
            pc_d = taken ? PC_W'(dest_f) : pc_inc;
          end else if (dest_sel == SEL_IO) begin
            out_d   = alu_res;
            state_d = S_OUT_WAIT;
          end else if (dest_sel == SEL_PC) begin
            pc_d = PC_W'(alu_res);
          end else begin
            wr_en = 1'b1;
            pc_d  = pc_inc;
          end
        end
      end
      S_IN_WAIT: begin
        if (core_if.in_valid) begin
          tok_d     = core_if.in_data;
          tok_vld_d = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_OUT_WAIT: begin
        if (core_if.out_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      tok_q     <= '0;
      tok_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      tok_q     <= tok_d;
      tok_vld_q <= tok_vld_d;
      out_q     <= out_d;
    end
  end

  // Codes NREGS..13 match no register, so those writes fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dest_sel == 4'(i)) regs_q[i] <= alu_res;
      end
    end
  end

  // Gating with rst_n keeps the request low for the whole reset interval.
  assign core_if.pm_req    = rst_n && (state_q == S_FETCH);
  assign core_if.pm_addr   = pc_q;
  assign core_if.in_ready  = (state_q == S_IN_WAIT) && core_if.in_valid;
  assign core_if.out_valid = (state_q == S_OUT_WAIT);
  assign core_if.out_data  = out_q;
  assign halted_o          = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_leg_core_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_leg_core_p : directed self-checking bench for leg_core_p (8- and 16-bit)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_leg_core_p;

  logic        clk = 1'b0;
  logic        rst8_n;
  logic        rst16_n;
  logic        pm_en8;
  logic        halted8;
  logic        halted16;
  logic [31:0] mem8  [64];
  logic [63:0] mem16 [64];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  leg_core_p_if #(.DATA_W(8),  .PC_W(8)) bus8  ();
  leg_core_p_if #(.DATA_W(16), .PC_W(8)) bus16 ();

  assign bus8.pm_valid  = bus8.pm_req & pm_en8;
  assign bus8.pm_data   = mem8[bus8.pm_addr[7:2]];
  assign bus16.pm_valid = bus16.pm_req;
  assign bus16.pm_data  = mem16[bus16.pm_addr[7:2]];

  leg_core_p #(.DATA_W(8), .NREGS(6), .PC_W(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst8_n),
    .core_if  (bus8),
    .halted_o (halted8)
  );

  leg_core_p #(.DATA_W(16), .NREGS(12), .PC_W(8)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst16_n),
    .core_if  (bus16),
    .halted_o (halted16)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins8(input logic [7:0] o, input logic [7:0] x1,
                                       input logic [7:0] x2, input logic [7:0] d);
    return {d, x2, x1, o};
  endfunction

  function automatic logic [63:0] ins16(input logic [15:0] o, input logic [15:0] x1,
                                        input logic [15:0] x2, input logic [15:0] d);
    return {d, x2, x1, o};
  endfunction

  task automatic ack8();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic expect_out16(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 12 && !bus16.out_valid; i++) tick();
    chk_eq({tag, "_vld"}, bus16.out_valid, 1'b1);
    chk_eq(tag, bus16.out_data, exp);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8_n          = 1'b0;
    rst16_n         = 1'b0;
    pm_en8          = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem8[i]  = '0;
      mem16[i] = '0;
    end

    mem8[0]  = ins8(8'hC0, 8'h05, 8'h03, 8'h00); // R0 = 5+3
    mem8[1]  = ins8(8'h80, 8'h00, 8'h00, 8'h0F); // out R0
    mem8[2]  = ins8(8'h40, 8'h0F, 8'h00, 8'h01); // R1 = in + 0
    mem8[3]  = ins8(8'h80, 8'h00, 8'h01, 8'h0F); // out R1
    mem8[4]  = ins8(8'h05, 8'h0F, 8'h0F, 8'h01); // R1 = in ^ in
    mem8[5]  = ins8(8'h80, 8'h00, 8'h01, 8'h0F); // out R1
    mem8[6]  = ins8(8'hC0, 8'h03, 8'h00, 8'h00); // R0 = 3
    mem8[7]  = ins8(8'h62, 8'h00, 8'h05, 8'h40); // R0 < 5 -> 0x40
    mem8[16] = ins8(8'h65, 8'h00, 8'h05, 8'h10); // R0 >= 5 not taken
    mem8[17] = ins8(8'h27, 8'h00, 8'h00, 8'h10); // never
    mem8[18] = ins8(8'h26, 8'h00, 8'h00, 8'h50); // always -> 0x50
    mem8[20] = ins8(8'hC0, 8'h58, 8'h00, 8'h0E); // PC = 0x58
    mem8[22] = ins8(8'h80, 8'h00, 8'h0E, 8'h0F); // out PC

    mem16[0] = ins16(16'h00C6, 16'h8001, 16'h0001, 16'h0002);
    mem16[1] = ins16(16'h0080, 16'h0000, 16'h0002, 16'h000F);
    mem16[2] = ins16(16'h00C1, 16'h0000, 16'h0001, 16'h000B);
    mem16[3] = ins16(16'h0080, 16'h0000, 16'h000B, 16'h000F);
    mem16[4] = ins16(16'h00C0, 16'h1234, 16'h0000, 16'h000C);
    mem16[5] = ins16(16'h0080, 16'h0000, 16'h000C, 16'h000F);
    mem16[6] = ins16(16'h00C7, 16'hFFFF, 16'h0004, 16'h0003);
    mem16[7] = ins16(16'h0080, 16'h0000, 16'h0003, 16'h000F);
    mem16[8] = ins16(16'h00C3, 16'h0F00, 16'h00F0, 16'h000F);
    mem16[9] = ins16(16'h0010, 16'h0000, 16'h0000, 16'h0000);

    tick();
    tick();
    chk_eq("rst_pm_req",    bus8.pm_req,    1'b0);
    chk_eq("rst_in_ready",  bus8.in_ready,  1'b0);
    chk_eq("rst_out_valid", bus8.out_valid, 1'b0);
    chk_eq("rst_out_data",  bus8.out_data,  8'h00);
    chk_eq("rst_halted",    halted8,        1'b0);

    rst8_n = 1'b1;
    #1;
    chk_eq("post_rst_pm_req",  bus8.pm_req,  1'b1);
    chk_eq("post_rst_pm_addr", bus8.pm_addr, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("stall_pm_req",  bus8.pm_req,  1'b1);
      chk_eq("stall_pm_addr", bus8.pm_addr, 8'h00);
    end
    pm_en8 = 1'b1;

    tick(); tick();
    chk_eq("pc_after_add", bus8.pm_addr, 8'h04);
    chk_eq("fetch_req",    bus8.pm_req,  1'b1);
    tick(); tick();
    chk_eq("out_add_vld",  bus8.out_valid, 1'b1);
    chk_eq("out_add_data", bus8.out_data,  8'h08);
    tick(); tick();
    chk_eq("out_hold_vld",  bus8.out_valid, 1'b1);
    chk_eq("out_hold_data", bus8.out_data,  8'h08);
    ack8();
    chk_eq("out_done_vld", bus8.out_valid, 1'b0);
    chk_eq("pc_after_out", bus8.pm_addr,   8'h08);

    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk_eq("in_idle_ready", bus8.in_ready, 1'b0);
      tick();
    end
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h2A;
    #1;
    chk_eq("in_accept", bus8.in_ready, 1'b1);
    tick();
    chk_eq("in_pulse_end", bus8.in_ready, 1'b0);
    bus8.in_valid = 1'b0;
    tick();
    chk_eq("pc_after_in", bus8.pm_addr, 8'h0C);
    tick(); tick();
    chk_eq("out_r1_in", bus8.out_data, 8'h2A);
    ack8();

    tick(); tick();
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h5A;
    #1;
    chk_eq("xor_in_accept", bus8.in_ready, 1'b1);
    tick();
    chk_eq("xor_one_token", bus8.in_ready, 1'b0);
    tick();
    chk_eq("pc_after_xor",    bus8.pm_addr,  8'h14);
    chk_eq("no_ready_fetch",  bus8.in_ready, 1'b0);
    bus8.in_valid = 1'b0;
    tick(); tick();
    chk_eq("out_xor", bus8.out_data, 8'h00);
    ack8();

    tick(); tick();
    tick(); tick();
    chk_eq("jmp_lt_taken", bus8.pm_addr, 8'h40);
    tick(); tick();
    chk_eq("jmp_ge_fall",  bus8.pm_addr, 8'h44);
    tick(); tick();
    chk_eq("jmp_never",    bus8.pm_addr, 8'h48);
    tick(); tick();
    chk_eq("jmp_always",   bus8.pm_addr, 8'h50);
    tick(); tick();
    chk_eq("alu_to_pc",    bus8.pm_addr, 8'h58);
    tick(); tick();
    chk_eq("out_pc_read",  bus8.out_data, 8'h58);
    tick(); tick(); tick();
    chk_eq("out_stall_vld", bus8.out_valid, 1'b1);

    rst8_n = 1'b0;
    #1;
    chk_eq("mid_rst_out_valid", bus8.out_valid, 1'b0);
    chk_eq("mid_rst_out_data",  bus8.out_data,  8'h00);
    chk_eq("mid_rst_pm_req",    bus8.pm_req,    1'b0);
    chk_eq("mid_rst_in_ready",  bus8.in_ready,  1'b0);
    chk_eq("mid_rst_halted",    halted8,        1'b0);

    mem8[0] = ins8(8'h80, 8'h00, 8'h00, 8'h0F); // out R0
    mem8[1] = ins8(8'h10, 8'h00, 8'h00, 8'h00); // HALT
    tick();
    rst8_n = 1'b1;
    #1;
    chk_eq("rerst_pm_addr", bus8.pm_addr, 8'h00);
    tick(); tick();
    chk_eq("reg_reset_val", bus8.out_data, 8'h00);
    ack8();
    tick(); tick();
    chk_eq("halt_flag",   halted8,     1'b1);
    chk_eq("halt_pm_req", bus8.pm_req, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk_eq("halt_sticky",     halted8,        1'b1);
    chk_eq("halt_req_low",    bus8.pm_req,    1'b0);
    chk_eq("halt_no_out",     bus8.out_valid, 1'b0);

    rst16_n = 1'b1;
    expect_out16("shl_wrap",  16'h0002);
    expect_out16("sub_wrap",  16'hFFFF);
    expect_out16("code12_rd", 16'h0000);
    expect_out16("shr",       16'h0FFF);
    expect_out16("or_out",    16'h0FF0);
    for (int i = 0; i < 12 && !halted16; i++) tick();
    chk_eq("halt16",        halted16,     1'b1);
    chk_eq("halt16_pm_req", bus16.pm_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
